clock_step_controller: RTL and testbench
========================================

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable cycles required before the debounced step level changes (20 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of pulse_count.
REQ-003 clock  input  1  system clock; the one clock, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 slow_clk  input  1  divided square wave from the frequency divider; asynchronous to clock.
REQ-006 step_btn  input  1  raw step push-button, active-high, bouncing, asynchronous.
REQ-007 mode_run  input  1  run/step switch, 1 = free run, asynchronous.
REQ-008 halt  input  1  CPU halt request, synchronous to clock, level.
REQ-009 cpu_en  output  1  one-cycle CPU advance strobe.
REQ-010 state_o  output  2  current FSM state: STOP=0, RUN=1, HALT=2.
REQ-011 pulse_count  output  CNT_W  number of cpu_en strobes issued.

Function
REQ-012 slow_clk, step_btn and mode_run SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 A slow_clk rise SHALL be detected as synchronized value 1 with previous synchronized value 0, giving a one-cycle tick 3 clocks after the edge is first sampled.
REQ-014 The debounced step level SHALL change only after the synchronized step_btn differs from it for exactly DEBOUNCE_CYCLES consecutive cycles; any mismatch gap SHALL restart the count.
REQ-015 A step press SHALL be the 0->1 transition of the debounced level, one cycle wide.
REQ-016 FSM states SHALL be STOP, RUN and HALT.
REQ-017 HALT entry: any state SHALL go to HALT when halt=1; this transition has highest priority.
REQ-018 STOP->RUN SHALL occur when synchronized mode_run=1 and halt=0.
REQ-019 RUN->STOP SHALL occur when synchronized mode_run=0 and halt=0.
REQ-020 HALT->STOP SHALL occur on a step press while halt=0; HALT SHALL ignore ticks and mode_run.
REQ-021 In RUN, cpu_en SHALL be 1 for the cycle after each tick.
REQ-022 In STOP, cpu_en SHALL be 1 for the cycle after each step press.
REQ-023 In HALT, cpu_en SHALL be 0.
REQ-024 cpu_en SHALL be registered, never wider than one cycle, and decided by the state current when the tick or press occurs.
REQ-025 If halt=1 coincides with a tick or press, no strobe SHALL issue.
REQ-026 A mode change coinciding with a tick SHALL act under the old state; the new state applies from the next cycle.
REQ-027 pulse_count SHALL increment by 1 on every cpu_en=1 cycle and wrap from all-ones to 0.
REQ-028 Step presses in RUN SHALL be ignored, and ticks in STOP SHALL be ignored.

Reset
REQ-029 reset=0 SHALL asynchronously set state to STOP, clear cpu_en and pulse_count, and clear all synchronizer, edge and debounce flops.
REQ-030 Reset release mid-press SHALL NOT produce a strobe until the button is stable high for DEBOUNCE_CYCLES after release.
REQ-031 Reset asserted mid-strobe SHALL drop cpu_en immediately.

Structure
REQ-032 A shared package SHALL hold the state encoding (STOP/RUN/HALT, 2 bits) and the DEBOUNCE_CYCLES default.
REQ-033 Debounce SHALL be one sub-module, button_debouncer (synchronizer, counter, level output), instantiated once.
REQ-034 The FSM, tick edge detector and counter SHALL reside in clock_step_controller; RTL size 120-400 lines.

Verification (DEBOUNCE_CYCLES=4, CNT_W=4)
REQ-035 Release reset, mode_run=1, slow_clk period 20 clocks for 3 periods -> state_o=1, three cpu_en pulses each 3 cycles after the slow_clk rise, pulse_count=3.
REQ-036 mode_run=0, step_btn bounces 1-0-1 then holds high 6 cycles -> exactly one cpu_en after 4 stable cycles plus sync; holding high gives no further pulse.
REQ-037 In RUN, assert halt on the cycle of a tick -> no cpu_en, state_o=2; then halt=0 plus step press -> state_o=0 with no strobe.
REQ-038 Issue 17 strobes -> pulse_count reads 15 then 0 then 1.
REQ-039 Pull reset low during the cpu_en cycle and while step_btn is high -> cpu_en=0 and pulse_count=0 immediately; after release, one strobe only after 4 stable-high cycles.
REQ-040 Toggle mode_run 1->0 on the cycle a tick is detected -> one strobe issued under RUN, then state_o=0 with no strobes from later ticks.

Source files
------------

// File: rtl/clock_step_controller_pkg.sv
// ----------------------------------------------------------------------------
// clock_step_controller_pkg
// Definitions shared by the clock step controller:
//   state_e                 - controller state encoding (STOP=0, RUN=1, HALT=2)
//   DEBOUNCE_CYCLES_DEFAULT - stable cycles before the step level may change
//                             (20 ms at a 50 MHz clock)
// ----------------------------------------------------------------------------
package clock_step_controller_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/clock_step_controller_if.sv
// ----------------------------------------------------------------------------
// clock_step_controller_if
// Groups the controller's control inputs and CPU-facing outputs.
//   slow_clk    - divided square wave, asynchronous to the system clock
//   step_btn    - raw step push-button, active-high, bouncing
//   mode_run    - run/step switch, 1 = free run
//   halt        - CPU halt request, synchronous level
//   cpu_en      - one-cycle CPU advance strobe
//   state_o     - current controller state
//   pulse_count - number of cpu_en strobes issued (wraps)
// Modports: master drives the inputs and observes the outputs,
//           slave is the controller side.
// ----------------------------------------------------------------------------
interface clock_step_controller_if #(
    parameter int CNT_W = 16
);
    logic             slow_clk;
    logic             step_btn;
    logic             mode_run;
    logic             halt;
    logic             cpu_en;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output slow_clk, step_btn, mode_run, halt,
        input  cpu_en, state_o, pulse_count
    );

    modport slave (
        input  slow_clk, step_btn, mode_run, halt,
        output cpu_en, state_o, pulse_count
    );
endinterface

// File: rtl/clock_step_controller_button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Synchronizes a bouncing push-button and produces a clean level that only
// follows the button after it has disagreed with the current level for
// DEBOUNCE_CYCLES consecutive clocks.
//   clock     - system clock
//   reset     - asynchronous, active-low
//   btn_async - raw button input
//   level     - debounced button level
// ----------------------------------------------------------------------------
module button_debouncer
    import clock_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_async,
    output logic level
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Any cycle where the synchronized button agrees with the level restarts
    // the count, so a single bounce forces a full fresh stable window.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/clock_step_controller.sv
// ----------------------------------------------------------------------------
// clock_step_controller
// Decides when the CPU advances: on every slow_clk rise in RUN, on every
// debounced step press in STOP, never in HALT. Counts issued strobes.
//   clock - system clock, all logic on its rising edge
//   reset - asynchronous, active-low
//   bus   - clock_step_controller_if.slave (slow_clk, step_btn, mode_run,
//           halt in; cpu_en, state_o, pulse_count out)
// Parameters: DEBOUNCE_CYCLES (step button stable window), CNT_W (counter).
// ----------------------------------------------------------------------------
module clock_step_controller
    import clock_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    clock_step_controller_if.slave   bus
);

    logic             slow_sync1_q, slow_sync1_d;
    logic             slow_sync2_q, slow_sync2_d;
    logic             slow_prev_q,  slow_prev_d;
    logic             mode_sync1_q, mode_sync1_d;
    logic             mode_sync2_q, mode_sync2_d;
    logic             btn_prev_q,   btn_prev_d;
    state_e           state_q,      state_d;
    logic             cpu_en_q,     cpu_en_d;
    logic [CNT_W-1:0] count_q,      count_d;

    logic             btn_level;
    logic             tick;
    logic             press;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .btn_async (bus.step_btn),
        .level     (btn_level)
    );

    // Synchronizers plus rising-edge detection. tick and press are single
    // cycle events taken from already-synchronized values.
    always_comb begin
        slow_sync1_d = bus.slow_clk;
        slow_sync2_d = slow_sync1_q;
        slow_prev_d  = slow_sync2_q;
        mode_sync1_d = bus.mode_run;
        mode_sync2_d = mode_sync1_q;
        btn_prev_d   = btn_level;
        tick         = slow_sync2_q & ~slow_prev_q;
        press        = btn_level & ~btn_prev_q;
    end

    // Next state: halt overrides everything; HALT is left only by a press.
    always_comb begin
        state_d = state_q;
        if (bus.halt) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_STOP: if (mode_sync2_q)  state_d = ST_RUN;
                ST_RUN:  if (!mode_sync2_q) state_d = ST_STOP;
                ST_HALT: if (press)         state_d = ST_STOP;
                default:                    state_d = ST_STOP;
            endcase
        end
    end

    // The strobe is decided by the state current at the tick/press, so a
    // simultaneous mode change still gets the old state's behaviour. The
    // counter advances on the same edge the strobe is registered.
    always_comb begin
        cpu_en_d = 1'b0;
        if (!bus.halt) begin
            case (state_q)
                ST_RUN:  cpu_en_d = tick;
                ST_STOP: cpu_en_d = press;
                default: cpu_en_d = 1'b0;
            endcase
        end
        count_d = count_q;
        if (cpu_en_d) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slow_sync1_q <= 1'b0;
            slow_sync2_q <= 1'b0;
            slow_prev_q  <= 1'b0;
            mode_sync1_q <= 1'b0;
            mode_sync2_q <= 1'b0;
            btn_prev_q   <= 1'b0;
            state_q      <= ST_STOP;
            cpu_en_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            slow_sync1_q <= slow_sync1_d;
            slow_sync2_q <= slow_sync2_d;
            slow_prev_q  <= slow_prev_d;
            mode_sync1_q <= mode_sync1_d;
            mode_sync2_q <= mode_sync2_d;
            btn_prev_q   <= btn_prev_d;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            count_q      <= count_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.state_o     = state_q;
    assign bus.pulse_count = count_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// ----------------------------------------------------------------------------
// tb_clock_step_controller
// Self-checking bench for clock_step_controller with DEBOUNCE_CYCLES=4 and
// CNT_W=4. Inputs change on the falling clock edge. Each expected strobe is
// queued with the cycle it must appear in and the pulse_count it must show;
// a monitor on the falling edge pops and compares when the strobe is due and
// flags any strobe that was not expected.
// Latencies from an input change at a falling edge (posedge count "cyc"):
//   slow_clk rise -> cpu_en visible at cyc+3
//   step press held stable -> cpu_en visible at cyc+7 (2 sync + 4 stable + 1)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_step_controller;
    import clock_step_controller_pkg::*;

    localparam int DB = 4;
    localparam int CW = 4;

    typedef struct {
        int            cyc;
        logic [CW-1:0] count;
    } strobe_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            fails = 0;
    strobe_t       sb_q[$];
    strobe_t       mon_e;
    logic [CW-1:0] exp_count = '0;

    clock_step_controller_if #(.CNT_W(CW)) bus();

    clock_step_controller #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: a due entry must coincide with cpu_en=1 and the
    // queued count; otherwise cpu_en must be low.
    always @(negedge clock) begin
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (bus.cpu_en !== 1'b1) begin
                fails++;
                $display("[TB] FAIL strobe_due cycle %0d: cpu_en=%b, required 1", cyc, bus.cpu_en);
            end
            checks++;
            if (bus.pulse_count !== mon_e.count) begin
                fails++;
                $display("[TB] FAIL strobe_count cycle %0d: pulse_count=%0d, required %0d",
                         cyc, bus.pulse_count, mon_e.count);
            end
        end else begin
            checks++;
            if (bus.cpu_en !== 1'b0) begin
                fails++;
                $display("[TB] FAIL unexpected_strobe cycle %0d: cpu_en=%b, required 0", cyc, bus.cpu_en);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_strobe(input int delay);
        strobe_t e;
        exp_count = exp_count + CW'(1);
        e.cyc   = cyc + delay;
        e.count = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input logic mode);
        @(negedge clock);
        reset        = 1'b0;
        bus.slow_clk = 1'b0;
        bus.step_btn = 1'b0;
        bus.mode_run = mode;
        bus.halt     = 1'b0;
        sb_q.delete();
        exp_count = '0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        checks++;
        if (bus.state_o !== 2'(ST_STOP)) begin
            fails++; $display("[TB] FAIL reset_state: state_o=%0d, required 0", bus.state_o);
        end
        checks++;
        if (bus.cpu_en !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_cpu_en: cpu_en=%b, required 0", bus.cpu_en);
        end
        checks++;
        if (bus.pulse_count !== '0) begin
            fails++; $display("[TB] FAIL reset_count: pulse_count=%0d, required 0", bus.pulse_count);
        end
    endtask

    task automatic test_run_mode();
        do_reset(1'b1);
        checks++;
        if (bus.state_o !== 2'(ST_RUN)) begin
            fails++; $display("[TB] FAIL run_state: state_o=%0d, required 1", bus.state_o);
        end
        for (int p = 0; p < 3; p++) begin
            bus.slow_clk = 1'b1;
            push_strobe(3);
            wait_cycles(10);
            bus.slow_clk = 1'b0;
            wait_cycles(10);
        end
        checks++;
        if (bus.pulse_count !== CW'(3)) begin
            fails++; $display("[TB] FAIL run_count: pulse_count=%0d, required 3", bus.pulse_count);
        end
    endtask

    task automatic test_step_debounce();
        do_reset(1'b0);
        bus.step_btn = 1'b1;
        wait_cycles(1);
        bus.step_btn = 1'b0;
        wait_cycles(1);
        bus.step_btn = 1'b1;
        push_strobe(7);
        wait_cycles(12);
        checks++;
        if (bus.pulse_count !== CW'(1)) begin
            fails++; $display("[TB] FAIL step_count: pulse_count=%0d, required 1", bus.pulse_count);
        end
        // Release plus a slow_clk period in STOP: neither may strobe.
        bus.step_btn = 1'b0;
        bus.slow_clk = 1'b1;
        wait_cycles(6);
        bus.slow_clk = 1'b0;
        wait_cycles(6);
        checks++;
        if (bus.state_o !== 2'(ST_STOP)) begin
            fails++; $display("[TB] FAIL step_state: state_o=%0d, required 0", bus.state_o);
        end
    endtask

    task automatic test_halt();
        do_reset(1'b1);
        bus.slow_clk = 1'b1;
        wait_cycles(2);
        bus.halt = 1'b1;
        wait_cycles(1);
        checks++;
        if (bus.state_o !== 2'(ST_HALT)) begin
            fails++; $display("[TB] FAIL halt_entry: state_o=%0d, required 2", bus.state_o);
        end
        bus.halt = 1'b0;
        bus.slow_clk = 1'b0;
        wait_cycles(4);
        bus.slow_clk = 1'b1;
        wait_cycles(4);
        checks++;
        if (bus.state_o !== 2'(ST_HALT)) begin
            fails++; $display("[TB] FAIL halt_hold: state_o=%0d, required 2", bus.state_o);
        end
        bus.mode_run = 1'b0;
        bus.slow_clk = 1'b0;
        wait_cycles(3);
        bus.step_btn = 1'b1;
        wait_cycles(6);
        checks++;
        if (bus.state_o !== 2'(ST_HALT)) begin
            fails++; $display("[TB] FAIL halt_before_press: state_o=%0d, required 2", bus.state_o);
        end
        wait_cycles(1);
        checks++;
        if (bus.state_o !== 2'(ST_STOP)) begin
            fails++; $display("[TB] FAIL halt_exit: state_o=%0d, required 0", bus.state_o);
        end
        checks++;
        if (bus.pulse_count !== '0) begin
            fails++; $display("[TB] FAIL halt_count: pulse_count=%0d, required 0", bus.pulse_count);
        end
        bus.step_btn = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_count_wrap();
        do_reset(1'b1);
        for (int i = 1; i <= 17; i++) begin
            bus.slow_clk = 1'b1;
            push_strobe(3);
            wait_cycles(4);
            if (i >= 15) begin
                checks++;
                if (bus.pulse_count !== CW'(i)) begin
                    fails++;
                    $display("[TB] FAIL wrap_count strobe %0d: pulse_count=%0d, required %0d",
                             i, bus.pulse_count, CW'(i));
                end
            end
            bus.slow_clk = 1'b0;
            wait_cycles(4);
        end
    endtask

    task automatic test_reset_mid_strobe();
        do_reset(1'b0);
        bus.step_btn = 1'b1;
        push_strobe(7);
        wait_cycles(7);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.cpu_en !== 1'b0) begin
            fails++; $display("[TB] FAIL midreset_cpu_en: cpu_en=%b, required 0", bus.cpu_en);
        end
        checks++;
        if (bus.pulse_count !== '0) begin
            fails++; $display("[TB] FAIL midreset_count: pulse_count=%0d, required 0", bus.pulse_count);
        end
        sb_q.delete();
        exp_count = '0;
        wait_cycles(3);
        reset = 1'b1;
        push_strobe(7);
        wait_cycles(10);
        checks++;
        if (bus.pulse_count !== CW'(1)) begin
            fails++; $display("[TB] FAIL midreset_after: pulse_count=%0d, required 1", bus.pulse_count);
        end
        bus.step_btn = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_mode_change_on_tick();
        do_reset(1'b1);
        bus.slow_clk = 1'b1;
        bus.mode_run = 1'b0;
        push_strobe(3);
        wait_cycles(3);
        checks++;
        if (bus.state_o !== 2'(ST_STOP)) begin
            fails++; $display("[TB] FAIL mode_tick_state: state_o=%0d, required 0", bus.state_o);
        end
        for (int p = 0; p < 2; p++) begin
            bus.slow_clk = 1'b0;
            wait_cycles(4);
            bus.slow_clk = 1'b1;
            wait_cycles(4);
        end
        checks++;
        if (bus.pulse_count !== CW'(1)) begin
            fails++; $display("[TB] FAIL mode_tick_count: pulse_count=%0d, required 1", bus.pulse_count);
        end
    endtask

    initial begin
        bus.slow_clk = 1'b0;
        bus.step_btn = 1'b0;
        bus.mode_run = 1'b0;
        bus.halt     = 1'b0;
        test_reset();
        test_run_mode();
        test_step_debounce();
        test_halt();
        test_count_wrap();
        test_reset_mid_strobe();
        test_mode_change_on_tick();
        wait_cycles(5);
        checks++;
        if (sb_q.size() != 0) begin
            fails++; $display("[TB] FAIL pending_strobes: %0d left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
